// File: rtl/counter_scheduler.sv
// Round-robin sharing of one interval counter between NUM_REQ requesters; each grant runs N enabled cycles, then pulses done.
// Latency: grant 1 cycle after req seen in IDLE; done 1 cycle after the last enabled count cycle; 2 idle cycles from done to next grant.
// Backpressure: enable=0 stalls the count indefinitely; dropping req of the active requester aborts the run without done.
module counter_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 4,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [ID_W-1:0]          active_id
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     count, count_nxt;
   logic [CNT_W-1:0]     target, target_nxt;
   logic [ID_W-1:0]      last, last_nxt;
   logic [NUM_REQ-1:0]   grant_nxt, done_nxt;
   logic                 busy_nxt;
   logic [ID_W-1:0]      active_id_nxt;

   // arbiter results
   logic                 any_req;
   logic [ID_W-1:0]      sel;
   logic [NUM_REQ-1:0]   sel_onehot;
   logic [CNT_W-1:0]     sel_len;
   logic [CNT_W-1:0]     len_arr [NUM_REQ];

   // run control during COUNT
   logic                 active_req;
   logic                 abort;
   logic                 finish;

   // Unpack the per-requester lengths so the selected one can be indexed by sel.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         len_arr[i] = req_len[i*CNT_W +: CNT_W];
      end
   end

   // Round-robin pick: first requester above the last winner, else the first at or below it.
   always_comb begin
      logic            hi_found;
      logic            lo_found;
      logic [ID_W-1:0] hi_sel;
      logic [ID_W-1:0] lo_sel;
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      // descending scan so the lowest matching index overwrites last
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (ID_W'(i) > last) begin
               hi_found = 1'b1;
               hi_sel   = ID_W'(i);
            end else begin
               lo_found = 1'b1;
               lo_sel   = ID_W'(i);
            end
         end
      end
      any_req = hi_found | lo_found;
      sel     = hi_found ? hi_sel : lo_sel;
   end

   // One-hot of the winner and its length; a zero length still runs one enabled cycle.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_onehot[i] = (sel == ID_W'(i));
      end
      sel_len = (len_arr[sel] == '0) ? CNT_ONE : len_arr[sel];
   end

   // Run status: grant is one-hot on the active requester, so its req is req masked by grant.
   always_comb begin
      active_req = |(req & grant);
      abort      = ~active_req;
      finish     = enable && (count == (target - CNT_ONE));
   end

   // State register plus registered outputs and datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= '0;
         target    <= '0;
         last      <= LAST_RST;
         grant     <= '0;
         done      <= '0;
         busy      <= 1'b0;
         active_id <= '0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         target    <= target_nxt;
         last      <= last_nxt;
         grant     <= grant_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         active_id <= active_id_nxt;
      end
   end

   // Next-state: abort wins over completion in the same COUNT cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = any_req ? S_COUNT : S_IDLE;
         S_COUNT: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (finish) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_COUNT;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath next values; defaults describe the idle output state.
   always_comb begin
      grant_nxt     = '0;
      done_nxt      = '0;
      busy_nxt      = 1'b0;
      active_id_nxt = '0;
      count_nxt     = count;
      target_nxt    = target;
      last_nxt      = last;
      case (state)
         S_IDLE: begin
            if (any_req) begin
               grant_nxt     = sel_onehot;
               busy_nxt      = 1'b1;
               active_id_nxt = sel;
               count_nxt     = '0;
               target_nxt    = sel_len;
               last_nxt      = sel;
            end
         end
         S_COUNT: begin
            if (abort) begin
               count_nxt = '0;
            end else if (finish) begin
               // done goes to the same requester that held grant
               done_nxt      = grant;
               busy_nxt      = 1'b1;
               active_id_nxt = active_id;
               count_nxt     = '0;
            end else begin
               grant_nxt     = grant;
               busy_nxt      = 1'b1;
               active_id_nxt = active_id;
               count_nxt     = enable ? (count + CNT_ONE) : count;
            end
         end
         default: begin
            count_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: per-cycle vector table through an expected-value queue, plus an async-reset sequence.
// Latency: outputs compared 1 ns after each rising edge against the record driven before that edge.
// Backpressure: enable patterns in the table exercise stalled counting.
module tb_counter_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [1:0]  active_id;

   int total = 0;
   int bad   = 0;
   logic mon_on = 1'b0;

   counter_scheduler #(.NUM_REQ(4), .CNT_W(4), .ID_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .req       (req),
      .req_len   (req_len),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .active_id (active_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [3:0]  req;
      logic [15:0] len;
      logic [3:0]  g;
      logic [3:0]  d;
      logic        b;
      logic [1:0]  id;
   } vec_t;

   vec_t vt[$];
   vec_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic en, input logic [3:0] r, input logic [15:0] l,
                      input logic [3:0] g, input logic [3:0] d, input logic b, input logic [1:0] id);
      vec_t v;
      v.rst = rst; v.en = en; v.req = r; v.len = l;
      v.g = g; v.d = d; v.b = b; v.id = id;
      vt.push_back(v);
   endtask

   // Invariants sampled on the falling edge: grant/done one-hot-or-zero and never overlapping.
   always @(negedge clk) begin
      if (mon_on && rst_n) begin
         chk("inv grant onehot0", {31'b0, $onehot0(grant)}, 32'd1);
         chk("inv done onehot0", {31'b0, $onehot0(done)}, 32'd1);
         chk("inv grant&done", {28'b0, grant & done}, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vec_t e;
      rst_n   = 1'b0;
      enable  = 1'b0;
      req     = 4'b0;
      req_len = 16'h0;

      // reset state
      add(1, 1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 0, 2'd0);
      // contention 0,2,0,2 (len0=2, len2=3), 2 cycles from done to next grant
      add(0, 1, 4'b0101, 16'h0302, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0001, 1, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0000, 0, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0100, 4'b0000, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0100, 4'b0000, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0100, 4'b0000, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0100, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0000, 0, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0001, 1, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0000, 0, 2'd0);
      add(0, 1, 4'b0101, 16'h0302, 4'b0100, 4'b0000, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0100, 4'b0000, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0100, 4'b0000, 1, 2'd2);
      add(0, 1, 4'b0101, 16'h0302, 4'b0000, 4'b0100, 1, 2'd2);
      add(0, 1, 4'b0000, 16'h0302, 4'b0000, 4'b0000, 0, 2'd0);
      // enable gating: len1=4, enable 1,0,1,0,... -> 7 grant cycles
      add(0, 0, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 1, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 0, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 1, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 0, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 1, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 0, 4'b0010, 16'h0040, 4'b0010, 4'b0000, 1, 2'd1);
      add(0, 1, 4'b0010, 16'h0040, 4'b0000, 4'b0010, 1, 2'd1);
      add(0, 1, 4'b0000, 16'h0040, 4'b0000, 4'b0000, 0, 2'd0);
      // abort: req3 (len5) dropped in 3rd COUNT cycle, pending req0 then served
      add(0, 1, 4'b1001, 16'h5002, 4'b1000, 4'b0000, 1, 2'd3);
      add(0, 1, 4'b1001, 16'h5002, 4'b1000, 4'b0000, 1, 2'd3);
      add(0, 1, 4'b1001, 16'h5002, 4'b1000, 4'b0000, 1, 2'd3);
      add(0, 1, 4'b0001, 16'h5002, 4'b0000, 4'b0000, 0, 2'd0);
      add(0, 1, 4'b0001, 16'h5002, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0001, 16'h5002, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0001, 16'h5002, 4'b0000, 4'b0001, 1, 2'd0);
      add(0, 1, 4'b0000, 16'h5002, 4'b0000, 4'b0000, 0, 2'd0);
      // req_len change during COUNT ignored (len0=2, then F)
      add(0, 1, 4'b0001, 16'h0002, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0001, 16'h000F, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0001, 16'h000F, 4'b0000, 4'b0001, 1, 2'd0);
      add(0, 1, 4'b0000, 16'h000F, 4'b0000, 4'b0000, 0, 2'd0);
      // zero length behaves as 1
      add(0, 1, 4'b0001, 16'h0000, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0001, 16'h0003, 4'b0000, 4'b0001, 1, 2'd0);
      add(0, 1, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 0, 2'd0);
      // abort beats completion in the same cycle
      add(0, 1, 4'b0001, 16'h0001, 4'b0001, 4'b0000, 1, 2'd0);
      add(0, 1, 4'b0000, 16'h0001, 4'b0000, 4'b0000, 0, 2'd0);
      add(0, 1, 4'b0000, 16'h0001, 4'b0000, 4'b0000, 0, 2'd0);

      mon_on = 1'b1;
      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         @(negedge clk);
         rst_n   = ~v.rst;
         enable  = v.en;
         req     = v.req;
         req_len = v.len;
         exp_q.push_back(v);
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            chk($sformatf("v%0d queue empty", i), 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("v%0d grant", i), {28'b0, grant}, {28'b0, e.g});
            chk($sformatf("v%0d done", i), {28'b0, done}, {28'b0, e.d});
            chk($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, e.b});
            chk($sformatf("v%0d active_id", i), {30'b0, active_id}, {30'b0, e.id});
         end
      end

      // Async reset in the middle of a long run (last=0, so req2 wins here).
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1; req = 4'b0100; req_len = 16'h0F00;
      @(posedge clk); #1;
      chk("rst_mid grant before", {28'b0, grant}, 32'h4);
      chk("rst_mid id before", {30'b0, active_id}, 32'd2);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      req   = 4'b0101;
      #1;
      chk("rst_mid grant async", {28'b0, grant}, 32'h0);
      chk("rst_mid done async", {28'b0, done}, 32'h0);
      chk("rst_mid busy async", {31'b0, busy}, 32'h0);
      chk("rst_mid id async", {30'b0, active_id}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid grant after", {28'b0, grant}, 32'h1);
      chk("rst_mid id after", {30'b0, active_id}, 32'd0);
      chk("rst_mid busy after", {31'b0, busy}, 32'd1);
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk); #1;
      chk("rst_mid abort grant", {28'b0, grant}, 32'h0);
      chk("rst_mid abort done", {28'b0, done}, 32'h0);

      @(negedge clk);
      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Shares one interval counter between NUM_REQ requesters using round-robin arbitration.
- Each requester asks for a run of N enabled clock cycles. The block grants the counter to one requester, counts that requester's length, pulses done back to it, then re-arbitrates.
- Sits between requesting control blocks and the shared tick/interval counting resource. Its global enable is the same qualifier the plain counter uses.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CNT_W, 4, width of each requested length and of the internal count.
- ID_W, 2, width of active_id; must satisfy NUM_REQ <= 2**ID_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  count qualifier; count advances only on cycles with enable=1.
- req  input  NUM_REQ  level request per requester; must stay high until done.
- req_len  input  NUM_REQ*CNT_W  packed lengths; requester i uses bits [i*CNT_W +: CNT_W]; sampled at grant.
- grant  output  NUM_REQ  one-hot; high only for the requester currently being counted.
- done  output  NUM_REQ  one-cycle pulse to the requester whose count completed.
- busy  output  1  high while in COUNT or DONE.
- active_id  output  ID_W  index of the granted requester; 0 when idle.

Behaviour:
- Reset (async, rst_n=0), all registered:
  - state=IDLE; grant=0, done=0, busy=0, active_id=0.
  - count=0, target=0.
  - rr pointer last=NUM_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is high, select the first set bit searching last+1, last+2, ... with modulo NUM_REQ wrap.
  - Next cycle: state=COUNT, grant[sel]=1, active_id=sel, busy=1, count=0, last=sel.
  - target=req_len[sel]; req_len=0 is treated as 1.
  - Arbitration latency: 1 cycle from req seen to grant.
- COUNT:
  - enable=1: count <= count+1. When count==target-1 with enable=1, the next state is DONE.
  - enable=0: count holds; the state may stay in COUNT indefinitely.
  - Abort: if req[active_id] is low in any COUNT cycle, go to IDLE next cycle. grant is cleared and busy falls, with no done pulse. Abort has priority over completion in the same cycle.
- DONE (exactly 1 cycle):
  - done[active_id]=1, grant=0, busy=1.
  - Next state is IDLE, with active_id=0 and busy=0.
- Completion latency: a length-L run with enable held high gives grant for L cycles, then done on the following cycle.
- Back-to-back: DONE -> IDLE -> COUNT. There are 2 cycles between the done pulse and the next grant.
- Re-request: a requester still high in IDLE after its done is eligible again but has the lowest priority (rr pointer). It is re-served immediately only if no other req is high.
- Late changes ignored: req_len changes during COUNT do not affect target. New req bits during COUNT/DONE wait for IDLE.
- Arithmetic: count and target are CNT_W bits; count never wraps because it stops at target-1. Maximum run is 2**CNT_W-1 enabled cycles.
- Invariants: grant is always one-hot or zero, done is always one-hot or zero, and grant and done are never both high.

Test Plan:
- Reset mid-COUNT: assert rst_n=0 while in COUNT -> grant, done, busy and active_id go to 0 immediately (async). After release, req[0] is served first.
- Single request: req=0001, len0=3, enable=1 -> grant=0001 for 3 cycles starting 1 cycle after req, then done=0001 for 1 cycle, then busy=0.
- Contention: req=0101 constant, len0=2, len2=3 -> order is 0, 2, 0, 2. Each done pulse matches its length, with a 2-cycle gap from done to the next grant.
- Enable gating: req=0010, len1=4, enable toggled 1,0,1,0,... -> grant held for 7 cycles, done=0010 after the 4th enabled cycle.
- Abort: req=1000, len3=5, req dropped after the 2nd COUNT cycle -> grant=0 next cycle, no done pulse, state IDLE. A pending req=0001 is then granted.
- Zero length: req=0001, len0=0 -> grant for 1 cycle, then done=0001. A req_len change during COUNT has no effect.
